frogger_lane_engine: RTL

Parametrised obstacle engine for the Frogger playfield. It replaces the fixed set of five single-car `car_ctrl` instances with NUM_LANES lanes of CARS_PER_LANE cars each, and gives every lane its own direction and frame-based period. It also provides a registered per-pixel draw flag, frog/car collision detection and a hit-freeze state machine. It sits between `Sync_To_Count`/`frogger_ctrl` and the colour mux in `frogger_game`.

---
 rtl/frogger_pkg.sv | 34 +++
 rtl/frogger_lane.sv | 86 ++++++++
 rtl/frogger_lane_engine.sv | 126 ++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: engine state encoding, coordinate widths and
// car placement/stepping helpers.
package frogger_pkg;

  localparam int unsigned COORD_W   = 5;
  localparam int unsigned TILE_SIZE = 32;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    FREEZE  = 2'd2
  } eng_state_e;

  // Starting column of car `car` in lane `lane`; cars are spread evenly across the row.
  function automatic logic [COORD_W-1:0] init_x(input int unsigned lane,
                                                input int unsigned car,
                                                input int unsigned cars_per_lane,
                                                input int unsigned grid_w);
    return COORD_W'((car * (grid_w / cars_per_lane) + lane) % grid_w);
  endfunction

  // One-tile move with wrap at either edge of the playfield.
  function automatic logic [COORD_W-1:0] step_x(input logic [COORD_W-1:0] x,
                                                input logic               dir,
                                                input int unsigned        grid_w);
    if (!dir) begin
      return (x == COORD_W'(grid_w - 1)) ? '0 : x + COORD_W'(1);
    end
    return (x == '0) ? COORD_W'(grid_w - 1) : x - COORD_W'(1);
  endfunction

endpackage

// File: rtl/frogger_lane.sv
// One road lane: car X registers, frame-period counter, stepping, and
// combinational draw/frog match against the lane's tile row.
module frogger_lane
  import frogger_pkg::*;
#(
  parameter int unsigned LANE_IDX      = 0,
  parameter int unsigned CARS_PER_LANE = 2,
  parameter int unsigned GRID_W        = 14,
  parameter int unsigned LANE_ROW      = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic               dir_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [COORD_W-1:0] col_i,
  input  logic [COORD_W-1:0] row_i,
  input  logic [COORD_W-1:0] frog_x_i,
  input  logic [COORD_W-1:0] frog_y_i,
  output logic               draw_match_c_o,
  output logic               frog_match_c_o
);

  logic [CARS_PER_LANE-1:0][COORD_W-1:0] car_x_q, car_x_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  step_c;
  logic                                  col_hit_c;
  logic                                  frog_hit_c;

  // Period counter; a counter already past a shortened period steps on the next tick.
  always_comb begin
    cnt_d  = cnt_q;
    step_c = 1'b0;
    if (load_i || clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (period_i == '0) begin
        cnt_d = '0;
      end else if (cnt_q >= period_i - CNT_W'(1)) begin
        cnt_d  = '0;
        step_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    car_x_d = car_x_q;
    for (int unsigned k = 0; k < CARS_PER_LANE; k++) begin
      if (load_i) begin
        car_x_d[k] = init_x(LANE_IDX, k, CARS_PER_LANE, GRID_W);
      end else if (step_c) begin
        car_x_d[k] = step_x(car_x_q[k], dir_i, GRID_W);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int unsigned k = 0; k < CARS_PER_LANE; k++) begin
        car_x_q[k] <= init_x(LANE_IDX, k, CARS_PER_LANE, GRID_W);
      end
    end else begin
      cnt_q   <= cnt_d;
      car_x_q <= car_x_d;
    end
  end

  always_comb begin
    col_hit_c  = 1'b0;
    frog_hit_c = 1'b0;
    for (int unsigned k = 0; k < CARS_PER_LANE; k++) begin
      if (car_x_q[k] == col_i)    col_hit_c  = 1'b1;
      if (car_x_q[k] == frog_x_i) frog_hit_c = 1'b1;
    end
  end

  assign draw_match_c_o = col_hit_c && (row_i == COORD_W'(LANE_ROW))
                          && (col_i < COORD_W'(GRID_W));
  assign frog_match_c_o = frog_hit_c && (frog_y_i == COORD_W'(LANE_ROW));

endmodule

// File: rtl/frogger_lane_engine.sv
// Multi-lane obstacle engine: per-lane car movement, registered draw flag,
// frog collision detection and the hit-freeze state machine.
module frogger_lane_engine
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 5,
  parameter int unsigned CARS_PER_LANE   = 2,
  parameter int unsigned GRID_W          = 14,
  parameter int unsigned FIRST_LANE_ROW  = 7,
  parameter int unsigned HIT_HOLD_FRAMES = 60
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Enable,
  input  logic                       i_Frame_Tick,
  input  logic [NUM_LANES-1:0]       i_Lane_Dir,
  input  logic [CNT_W*NUM_LANES-1:0] i_Lane_Period,
  input  logic [COORD_W-1:0]         i_Col_Count_Div,
  input  logic [COORD_W-1:0]         i_Row_Count_Div,
  input  logic [COORD_W-1:0]         i_Frog_X,
  input  logic [COORD_W-1:0]         i_Frog_Y,
  output logic                       o_Draw_Car,
  output logic                       o_Collide,
  output logic                       o_Hit,
  output logic [STATE_W-1:0]         o_State
);

  eng_state_e           state_q, state_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic                 draw_q, collide_q, hit_q;
  logic                 hit_c;
  logic                 draw_c, collide_c;
  logic                 lane_load_c, lane_clear_c, lane_tick_c;
  logic [NUM_LANES-1:0] lane_draw_c, lane_frog_c;

  assign lane_load_c  = (state_q == IDLE);
  assign lane_clear_c = hit_c;
  assign lane_tick_c  = i_Frame_Tick && i_Enable && (state_q == RUNNING) && !hit_c;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    frogger_lane #(
      .LANE_IDX      (l),
      .CARS_PER_LANE (CARS_PER_LANE),
      .GRID_W        (GRID_W),
      .LANE_ROW      (FIRST_LANE_ROW + l)
    ) u_lane (
      .clk_i          (i_Clk),
      .rst_i          (i_Reset),
      .load_i         (lane_load_c),
      .clear_i        (lane_clear_c),
      .tick_i         (lane_tick_c),
      .dir_i          (i_Lane_Dir[l]),
      .period_i       (i_Lane_Period[CNT_W*l +: CNT_W]),
      .col_i          (i_Col_Count_Div),
      .row_i          (i_Row_Count_Div),
      .frog_x_i       (i_Frog_X),
      .frog_y_i       (i_Frog_Y),
      .draw_match_c_o (lane_draw_c[l]),
      .frog_match_c_o (lane_frog_c[l])
    );
  end

  assign draw_c    = |lane_draw_c;
  assign collide_c = |lane_frog_c;

  // Hits fire only on a rising collision edge, so an overlap persisting out of FREEZE is ignored.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    hit_c   = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        state_d = RUNNING;
      end
      RUNNING: begin
        hold_d = '0;
        if (collide_c && !collide_q) begin
          hit_c   = 1'b1;
          state_d = FREEZE;
        end
      end
      FREEZE: begin
        if (i_Frame_Tick) begin
          if (hold_q == CNT_W'(HIT_HOLD_FRAMES - 1)) begin
            hold_d  = '0;
            state_d = RUNNING;
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
        end
      end
      default: begin
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
    if (!i_Enable) begin
      hit_c   = 1'b0;
      hold_d  = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      draw_q    <= 1'b0;
      collide_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      draw_q    <= draw_c;
      collide_q <= collide_c;
      hit_q     <= hit_c;
    end
  end

  assign o_Draw_Car = draw_q;
  assign o_Collide  = collide_q;
  assign o_Hit      = hit_q;
  assign o_State    = STATE_W'(state_q);

endmodule
